cache_associativity: RTL and testbench
======================================

CACHE_ASSOCIATIVITY -- requirements
Module: cache_associativity

Interface
REQ-001 SHALL have parameter EPOCH_LEN, default 256, meaning completed accesses per evaluation epoch (power of two).
REQ-002 SHALL have parameter CONF_HI, default 64, meaning conflict count per epoch above which associativity is raised.
REQ-003 SHALL have parameter CONF_LO, default 8, meaning conflict count per epoch below which associativity is lowered.
REQ-004 SHALL have parameter BAL_THR, default 96, meaning PLRU-root imbalance magnitude above which associativity is lowered.
REQ-005 SHALL have port clk, input, 1, the only clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1; asynchronous, active-high reset.
REQ-007 SHALL have port cache_address, input, cache_address_t (32), with fields tag, set_index and offset.
REQ-008 SHALL have port cpu_request, input, 1; a read or write is being presented.
REQ-009 SHALL have port cache_ready, input, 1; the current request completes this cycle.
REQ-010 SHALL have port plru_bit0, input, 1; PLRU root bit of the accessed set (0 = left half, 1 = right half).
REQ-011 SHALL have port tie, input, 1; the PLRU root is balanced, so no half is preferred.
REQ-012 SHALL have port setup_ready, input, 1; the cache controller can accept a new setup.
REQ-013 SHALL have port setup_reg, output, 2; proposed setup (0 DM, 1 2-way, 2 4-way, 3 8-way).
REQ-014 SHALL have port setup_valid, output, 1; setup_reg holds a pending proposal.
REQ-015 SHALL have port setup_update, output, 1; one-cycle pulse when the proposal is accepted.

Function
REQ-016 An access SHALL be sampled only in a cycle with cpu_request=1 and cache_ready=1.
REQ-017 Each sampled access SHALL increment an epoch counter (width log2(EPOCH_LEN)+1).
REQ-018 A per-set history (valid bit and last tag, indexed by set_index) SHALL be kept.
REQ-019 On a sampled access to an invalid entry, the entry SHALL be filled and SHALL NOT count as a conflict.
REQ-020 On a sampled access to a valid entry with a different tag, a saturating conflict counter SHALL increment and the entry SHALL be overwritten with the new tag.
REQ-021 A same-tag sampled access SHALL leave the conflict counter unchanged.
REQ-022 Per sampled access, the 8-bit signed imbalance counter SHALL change as follows: tie=1, unchanged; otherwise +1 if plru_bit0=1, else -1; saturating at +127/-127.
REQ-023 At the sample that makes the epoch count equal EPOCH_LEN, the block SHALL evaluate, with cur the committed setup:
- conflicts > CONF_HI and cur<3: propose cur+1;
- otherwise, (conflicts < CONF_LO or |imbalance| > BAL_THR) and cur>0: propose cur-1;
- otherwise: no proposal.
REQ-024 The raise rule SHALL take priority over the lower rule.
REQ-025 After evaluation, the epoch, conflict and imbalance counters SHALL clear on the next cycle.
REQ-026 A proposal SHALL set setup_valid=1 and setup_reg=proposal on the next cycle, and both SHALL be held stable until accepted.
REQ-027 Acceptance SHALL occur in a cycle with setup_valid=1 and setup_ready=1.
REQ-028 On acceptance, setup_update SHALL pulse for exactly that cycle, cur SHALL load setup_reg on the next edge, and setup_valid SHALL drop on the next edge.
REQ-029 Sampling SHALL continue while a proposal is pending.
REQ-030 An epoch ending while a proposal is pending SHALL discard its decision and still clear its counters.
REQ-031 When no proposal is pending, setup_reg SHALL equal cur.
REQ-032 Per-set history SHALL be retained across epochs and setup changes.
REQ-033 Outputs SHALL be registered or derived from registers only, except setup_update = setup_valid & setup_ready.

Reset
REQ-034 While rst=1 the following SHALL hold:
- cur=0 and setup_reg=0;
- setup_valid=0 and setup_update=0;
- all counters zero and all history valid bits clear.
REQ-035 An asserted rst SHALL abort any pending proposal without a setup_update pulse.

Structure
REQ-036 The following SHALL be taken from the shared package mutative_types:
- cache_address_t;
- TAG_BITS, SET_BITS and OFFSET_BITS;
- the setup encoding constants.
REQ-037 The per-set history SHALL be a sub-module, assoc_tag_history: combinational read, synchronous write, async reset of valid bits.

Verification
REQ-038 Run 256 sampled accesses, each alternating between two tags in set 0, with tie=1 and cur=0. The bench SHALL see setup_valid=1, setup_reg=1; with setup_ready=1, a one-cycle setup_update and then setup_valid=0.
REQ-039 With cur=1, run 256 sampled accesses to one tag per set and tie=1. Conflicts=0<8, so the bench SHALL see setup_reg=0 proposed.
REQ-040 With cur=2, run 256 accesses, 20 of them conflicts, with plru_bit0=1 and tie=0. Imbalance=127>96, so the bench SHALL see setup_reg=1 proposed.
REQ-041 Use the REQ-038 stimulus but hold setup_ready=0 for 300 cycles while another epoch completes. The bench SHALL see setup_reg stay 1, no new proposal, and setup_update only once setup_ready rises.
REQ-042 Assert rst while setup_valid=1. The bench SHALL see setup_valid=0 immediately, no setup_update, setup_reg=0, and the next epoch's first access to set 0 not counted as a conflict.
REQ-043 Apply cpu_request=1 with cache_ready=0 for 1000 cycles. The bench SHALL see no epoch evaluation and all counters unchanged.

Source files
------------

// File: rtl/cache_associativity_pkg.sv
// Shared address layout and setup encoding for the adaptive-associativity monitor.
package mutative_types;
  localparam int TAG_BITS    = 20;
  localparam int SET_BITS    = 6;
  localparam int OFFSET_BITS = 6;
  localparam int NUM_SETS    = 1 << SET_BITS;

  typedef struct packed {
    logic [TAG_BITS-1:0]    tag;
    logic [SET_BITS-1:0]    set_index;
    logic [OFFSET_BITS-1:0] offset;
  } cache_address_t;

  localparam logic [1:0] SETUP_DM   = 2'd0;
  localparam logic [1:0] SETUP_2WAY = 2'd1;
  localparam logic [1:0] SETUP_4WAY = 2'd2;
  localparam logic [1:0] SETUP_8WAY = 2'd3;
endpackage

// File: rtl/cache_associativity_history.sv
// Per-set last-tag history: combinational read, clocked write, valid bits cleared by reset.
module assoc_tag_history
  import mutative_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] rd_set,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  input  logic                wr_en,
  input  logic [SET_BITS-1:0] wr_set,
  input  logic [TAG_BITS-1:0] wr_tag
);
  logic [NUM_SETS-1:0] valid;
  logic [TAG_BITS-1:0] tags [NUM_SETS];

  assign rd_valid = valid[rd_set];
  assign rd_tag   = tags[rd_set];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid <= '0;
    else if (wr_en) valid[wr_set] <= 1'b1;
  end

  // Tag storage needs no reset: it is only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) tags[wr_set] <= wr_tag;
  end
endmodule

// File: rtl/cache_associativity.sv
// Watches completed accesses per epoch and proposes one-step associativity changes.
module cache_associativity
  import mutative_types::*;
#(
  parameter int EPOCH_LEN = 256,
  parameter int CONF_HI   = 64,
  parameter int CONF_LO   = 8,
  parameter int BAL_THR   = 96
) (
  input  logic           clk,
  input  logic           rst,
  input  cache_address_t cache_address,
  input  logic           cpu_request,
  input  logic           cache_ready,
  input  logic           plru_bit0,
  input  logic           tie,
  input  logic           setup_ready,
  output logic [1:0]     setup_reg,
  output logic           setup_valid,
  output logic           setup_update
);
  localparam int EW = $clog2(EPOCH_LEN) + 1;

  logic [EW-1:0]       epoch_cnt, conf_cnt, conf_nxt;
  logic signed [7:0]   imb, imb_nxt;
  logic [7:0]          imb_mag;
  logic [1:0]          cur, prop_val;
  logic                sample, conflict, epoch_end, prop_en, accept;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic                unused;

  assign unused = ^cache_address.offset;

  assoc_tag_history u_hist (
    .clk      (clk),
    .rst      (rst),
    .rd_set   (cache_address.set_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .wr_en    (sample),
    .wr_set   (cache_address.set_index),
    .wr_tag   (cache_address.tag)
  );

  assign sample       = cpu_request & cache_ready;
  assign conflict     = sample & rd_valid & (rd_tag != cache_address.tag);
  assign epoch_end    = sample && (epoch_cnt == EW'(EPOCH_LEN - 1));
  assign accept       = setup_valid & setup_ready;
  assign setup_update = accept;

  // Decision uses counter values that already include the epoch's final access.
  always_comb begin
    conf_nxt = conf_cnt;
    if (conflict && conf_cnt != '1) conf_nxt = conf_cnt + 1'b1;
    imb_nxt = imb;
    if (sample && !tie) begin
      if (plru_bit0 && imb != 8'sd127)       imb_nxt = imb + 8'sd1;
      else if (!plru_bit0 && imb != -8'sd127) imb_nxt = imb - 8'sd1;
    end
    imb_mag  = imb_nxt[7] ? 8'(-imb_nxt) : 8'(imb_nxt);
    prop_en  = 1'b0;
    prop_val = cur;
    if (conf_nxt > EW'(CONF_HI) && cur != SETUP_8WAY) begin
      prop_en  = 1'b1;
      prop_val = cur + 2'd1;
    end else if ((conf_nxt < EW'(CONF_LO) || imb_mag > 8'(BAL_THR)) && cur != SETUP_DM) begin
      prop_en  = 1'b1;
      prop_val = cur - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epoch_cnt   <= '0;
      conf_cnt    <= '0;
      imb         <= '0;
      cur         <= SETUP_DM;
      setup_reg   <= SETUP_DM;
      setup_valid <= 1'b0;
    end else begin
      if (epoch_end) begin
        epoch_cnt <= '0;
        conf_cnt  <= '0;
        imb       <= '0;
      end else if (sample) begin
        epoch_cnt <= epoch_cnt + 1'b1;
        conf_cnt  <= conf_nxt;
        imb       <= imb_nxt;
      end
      // A pending proposal swallows any epoch decision until it is accepted.
      if (accept) begin
        cur         <= setup_reg;
        setup_valid <= 1'b0;
      end else if (epoch_end && !setup_valid && prop_en) begin
        setup_reg   <= prop_val;
        setup_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_associativity.sv
// Randomized bench for cache_associativity against an epoch-level behavioural model.
module tb_cache_associativity;
  import mutative_types::*;

  localparam int EPOCH_LEN = 256;
  localparam int CONF_HI   = 64;
  localparam int CONF_LO   = 8;
  localparam int BAL_THR   = 96;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  cache_address_t cache_address = '0;
  logic           cpu_request = 1'b0, cache_ready = 1'b0;
  logic           plru_bit0 = 1'b0, tie = 1'b1, setup_ready = 1'b0;
  logic [1:0]     setup_reg;
  logic           setup_valid, setup_update;

  int vecs = 0, errs = 0;

  // model state
  int m_epoch, m_conf, m_imb, m_cur, m_prop;
  bit m_pend;
  bit m_valid [NUM_SETS];
  int m_tag   [NUM_SETS];

  cache_associativity #(.EPOCH_LEN(EPOCH_LEN), .CONF_HI(CONF_HI), .CONF_LO(CONF_LO),
                        .BAL_THR(BAL_THR)) dut (
    .clk(clk), .rst(rst), .cache_address(cache_address), .cpu_request(cpu_request),
    .cache_ready(cache_ready), .plru_bit0(plru_bit0), .tie(tie), .setup_ready(setup_ready),
    .setup_reg(setup_reg), .setup_valid(setup_valid), .setup_update(setup_update)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_epoch = 0; m_conf = 0; m_imb = 0; m_cur = 0; m_prop = 0; m_pend = 0;
    for (int i = 0; i < NUM_SETS; i++) begin m_valid[i] = 0; m_tag[i] = 0; end
  endtask

  task automatic model_sample(input int set, input int tag, input bit plru, input bit t);
    int mag;
    if (m_valid[set] && m_tag[set] != tag) m_conf++;
    m_valid[set] = 1; m_tag[set] = tag;
    if (!t) m_imb = plru ? ((m_imb < 127) ? m_imb + 1 : 127) : ((m_imb > -127) ? m_imb - 1 : -127);
    m_epoch++;
    if (m_epoch == EPOCH_LEN) begin
      mag = (m_imb < 0) ? -m_imb : m_imb;
      if (!m_pend) begin
        if (m_conf > CONF_HI && m_cur < 3) begin m_pend = 1; m_prop = m_cur + 1; end
        else if ((m_conf < CONF_LO || mag > BAL_THR) && m_cur > 0) begin m_pend = 1; m_prop = m_cur - 1; end
      end
      m_epoch = 0; m_conf = 0; m_imb = 0;
    end
  endtask

  task automatic do_access(input int set, input int tag, input bit plru, input bit t);
    cache_address.tag       = TAG_BITS'(tag);
    cache_address.set_index = SET_BITS'(set);
    cache_address.offset    = OFFSET_BITS'($urandom);
    plru_bit0 = plru; tie = t; cpu_request = 1; cache_ready = 1;
    @(posedge clk);
    model_sample(set, tag, plru, t);
    #1;
    cpu_request = 0; cache_ready = 0;
    vecs++;
    if (setup_valid !== m_pend || setup_reg !== 2'(m_pend ? m_prop : m_cur) ||
        setup_update !== (m_pend & setup_ready)) begin
      errs++;
      $display("FAIL access t=%0t: valid=%b reg=%0d upd=%b, want valid=%b reg=%0d upd=%b",
               $time, setup_valid, setup_reg, setup_update, m_pend,
               m_pend ? m_prop : m_cur, m_pend & setup_ready);
    end
  endtask

  task automatic do_idle(input int n, input bit stall);
    cpu_request = stall; cache_ready = 0;
    cache_address = cache_address_t'($urandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (setup_valid !== m_pend || setup_reg !== 2'(m_pend ? m_prop : m_cur) ||
          setup_update !== (m_pend & setup_ready)) begin
        errs++;
        $display("FAIL idle t=%0t: valid=%b reg=%0d upd=%b, want valid=%b reg=%0d",
                 $time, setup_valid, setup_reg, setup_update, m_pend, m_pend ? m_prop : m_cur);
      end
    end
    cpu_request = 0;
  endtask

  task automatic do_accept(input string name);
    bit exp_upd;
    setup_ready = 1; #1;
    exp_upd = m_pend;
    vecs++;
    if (setup_update !== exp_upd) begin
      errs++; $display("FAIL %s update pulse: got %b want %b", name, setup_update, exp_upd);
    end
    @(posedge clk);
    if (m_pend) begin m_cur = m_prop; m_pend = 0; end
    #1; setup_ready = 0;
    vecs++;
    if (setup_valid !== 1'b0 || setup_update !== 1'b0 || setup_reg !== 2'(m_cur)) begin
      errs++;
      $display("FAIL %s after accept: valid=%b upd=%b reg=%0d want valid=0 upd=0 reg=%0d",
               name, setup_valid, setup_update, setup_reg, m_cur);
    end
  endtask

  task automatic expect_pending(input string name, input int prop);
    vecs++;
    if (setup_valid !== 1'b1 || setup_reg !== 2'(prop)) begin
      errs++;
      $display("FAIL %s proposal: valid=%b reg=%0d want valid=1 reg=%0d",
               name, setup_valid, setup_reg, prop);
    end
  endtask

  task automatic raise_epoch();
    for (int i = 0; i < EPOCH_LEN; i++) do_access(0, (i % 2) ? 2 : 1, 0, 1);
  endtask

  task automatic test_reset();
    rst = 1; setup_ready = 1;
    repeat (2) @(posedge clk);
    #1; model_reset();
    vecs++;
    if (setup_valid !== 0 || setup_update !== 0 || setup_reg !== 0) begin
      errs++; $display("FAIL reset: valid=%b upd=%b reg=%0d want 0 0 0",
                       setup_valid, setup_update, setup_reg);
    end
    rst = 0; setup_ready = 0;
    do_idle(2, 0);
  endtask

  task automatic test_raise();
    int want;
    want = m_cur + 1;
    raise_epoch();
    expect_pending("raise", want);
    do_idle(3, 0);
    do_accept("raise");
  endtask

  task automatic test_imbalance();
    for (int i = 0; i < 21; i++) do_access(4, 10 + (i % 2), 1, 0);
    for (int i = 21; i < EPOCH_LEN; i++) do_access(5, 7, 1, 0);
    expect_pending("imbalance", 1);
    do_accept("imbalance");
  endtask

  task automatic test_lower();
    for (int i = 0; i < EPOCH_LEN; i++) do_access(i % NUM_SETS, 100 + (i % NUM_SETS), 0, 1);
    expect_pending("lower", 0);
    do_accept("lower");
  endtask

  task automatic test_pending_hold();
    raise_epoch();
    expect_pending("hold first", 1);
    raise_epoch();
    do_idle(300 - EPOCH_LEN, 0);
    expect_pending("hold second", 1);
    do_accept("hold");
  endtask

  task automatic test_stall();
    for (int i = 0; i < EPOCH_LEN / 2; i++) do_access(0, (i % 2) ? 2 : 1, 0, 1);
    do_idle(1000, 1);
    for (int i = EPOCH_LEN / 2; i < EPOCH_LEN; i++) do_access(0, (i % 2) ? 2 : 1, 0, 1);
    expect_pending("stall", 2);
    do_accept("stall");
  endtask

  task automatic test_random();
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < EPOCH_LEN; i++) begin
        do_access($urandom_range(0, 7), $urandom_range(0, e), $urandom_range(0, 1),
                  $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) do_idle($urandom_range(1, 3), $urandom_range(0, 1));
      end
      do_accept("random");
    end
  endtask

  task automatic test_reset_pending();
    test_reset();
    raise_epoch();
    expect_pending("rst pending", 1);
    rst = 1; setup_ready = 1;
    #1;
    vecs++;
    if (setup_valid !== 0 || setup_update !== 0 || setup_reg !== 0) begin
      errs++; $display("FAIL async reset: valid=%b upd=%b reg=%0d want 0 0 0",
                       setup_valid, setup_update, setup_reg);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (setup_update !== 0 || setup_valid !== 0) begin
        errs++; $display("FAIL reset hold: upd=%b valid=%b want 0 0", setup_update, setup_valid);
      end
    end
    rst = 0; setup_ready = 0; model_reset();
    // exactly CONF_HI conflicts unless the first set-0 access were wrongly counted
    do_access(0, 77, 0, 1);
    for (int i = 0; i < CONF_HI + 1; i++) do_access(2, 1000 + i, 0, 1);
    for (int i = CONF_HI + 2; i < EPOCH_LEN; i++) do_access(3, 5, 0, 1);
    do_idle(2, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_raise();          // 0 -> 1
    test_raise();          // 1 -> 2
    test_imbalance();      // 2 -> 1
    test_lower();          // 1 -> 0
    test_pending_hold();   // 0 -> 1
    test_stall();          // 1 -> 2
    test_random();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
